// File: rtl/reg_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_arb_pkg: FSM encodings and default sizing shared by bank arbiters.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package reg_arb_pkg;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_ADDR_W  = 3;
endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_picker: combinational round-robin pick (rotate, priority, unrotate).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter  int N     = DEF_NUM_REQ,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     elig_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     win_o,
  output logic             any_o
);
  logic [PTR_W-1:0] shift;
  logic [2*N-1:0]   dbl_elig;
  logic [2*N-1:0]   dbl_pick;
  logic [N-1:0]     rot;
  logic [N-1:0]     pick;

  // Search starts one past the last winner, so rotate that index down to bit 0.
  always_comb begin
    shift    = (ptr_i == PTR_W'(N - 1)) ? '0 : ptr_i + 1'b1;
    dbl_elig = {elig_i, elig_i} >> shift;
    rot      = dbl_elig[N-1:0];
    pick     = rot & (~rot + N'(1));
    dbl_pick = {pick, pick} << shift;
    win_o    = dbl_pick[2*N-1:N];
  end

  assign any_o = |elig_i;
endmodule
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_bank_arbiter: round-robin sharing of one register bank; optional     |
// | REG_ARB_LOCK_EN adds a lock port for atomic read-modify-write. Rev 1.0   |
// +--------------------------------------------------------------------------+
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*WIDTH-1:0]  wdata,
`ifdef REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [WIDTH-1:0]          rdata,
  output logic                      rvalid,
  output logic [NUM_REQ-1:0]        rid,
  output logic [ADDR_W-1:0]         bank_addr,
  output logic                      bank_load,
  output logic [WIDTH-1:0]          bank_in,
  input  logic [WIDTH-1:0]          bank_out
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [0:0]         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, rid_q, rid_d;
  logic [NUM_REQ-1:0] elig, win;
  logic               any, locked;
  logic               load_q, load_d, rvalid_q, rvalid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;

`ifdef REG_ARB_LOCK_EN
  logic [NUM_REQ-1:0] owner;
  // A locked owner is the only eligible requester and bypasses its own mask.
  assign owner  = (state_q == ST_GRANT) ? (gnt_q & lock & req) : '0;
  assign locked = |owner;
  assign elig   = locked ? owner : (req & ~gnt_q);
`else
  assign locked = 1'b0;
  assign elig   = req & ~gnt_q;
`endif

  rr_picker #(.N(NUM_REQ)) u_picker (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .win_o  (win),
    .any_o  (any)
  );

  always_comb begin
    state_d = any ? ST_GRANT : ST_IDLE;
    gnt_d   = win;
    ptr_d   = ptr_q;
    load_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win[k]) begin
        load_d  = we[k];
        addr_d  = addr[k*ADDR_W +: ADDR_W];
        wdata_d = wdata[k*WIDTH +: WIDTH];
        if (!locked) begin
          ptr_d = PTR_W'(k);
        end
      end
    end
    // A read grant samples the bank at the end of its GRANT cycle.
    rvalid_d = (state_q == ST_GRANT) && !load_q;
    rid_d    = rvalid_d ? gnt_q : rid_q;
    rdata_d  = rvalid_d ? bank_out : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= PTR_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      load_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      load_q   <= load_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign bank_load = load_q;
  assign bank_addr = addr_q;
  assign bank_in   = wdata_q;
  assign rvalid    = rvalid_q;
  assign rid       = rid_q;
  assign rdata     = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_bank_arbiter: scoreboard bench with a behavioural 8x16 bank.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_reg_bank_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int A = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, we, gnt, rid;
  logic [N*A-1:0] addr;
  logic [N*W-1:0] wdata;
  logic [W-1:0]   rdata, bank_in, bank_out;
  logic           rvalid, bank_load;
  logic [A-1:0]   bank_addr;
`ifdef REG_ARB_LOCK_EN
  logic [N-1:0]   lock;
`endif

  always #5 clk = ~clk;

  reg_bank_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADDR_W(A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
`ifdef REG_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rid       (rid),
    .bank_addr (bank_addr),
    .bank_load (bank_load),
    .bank_in   (bank_in),
    .bank_out  (bank_out)
  );

  logic [W-1:0] bank_mem [2**A];
  logic         bank_ready = 1'b0;
  assign bank_out = bank_mem[bank_addr];
  always @(posedge clk) begin
    if (!bank_ready) begin
      for (int i = 0; i < 2**A; i++) bank_mem[i] <= 16'hF000 + 16'(i);
      bank_ready <= 1'b1;
    end else if (bank_load) begin
      bank_mem[bank_addr] <= bank_in;
    end
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [N-1:0] gnt;
    logic [A-1:0] addr;
    logic         load;
    logic [W-1:0] din;
    int           cyc;
  } gexp_t;
  typedef struct {
    logic [W-1:0] data;
    logic [N-1:0] id;
    int           cyc;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t g_e;
  rexp_t r_e;
  int    n_checks = 0;
  int    n_pass   = 0;
  logic [W-1:0] last_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or read data.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != '0) begin
        chk("gnt_onehot", 64'($countones(gnt)), 64'd1);
        if (gq.size() == 0) begin
          n_checks++;
          $display("FAIL gnt_unexpected: got gnt=%b, expected no grant (cycle %0d)", gnt, cyc_cnt);
        end else begin
          g_e = gq.pop_front();
          chk("gnt_vec", gnt, g_e.gnt);
          chk("gnt_cycle", cyc_cnt, g_e.cyc);
          chk("bank_addr", bank_addr, g_e.addr);
          chk("bank_load", bank_load, g_e.load);
          chk("bank_in", bank_in, g_e.din);
        end
      end
      if (rvalid) begin
        if (rq.size() == 0) begin
          n_checks++;
          $display("FAIL rvalid_unexpected: got rdata=%h, expected no read (cycle %0d)", rdata, cyc_cnt);
        end else begin
          r_e = rq.pop_front();
          chk("rdata", rdata, r_e.data);
          chk("rid", rid, r_e.id);
          chk("rvalid_cycle", cyc_cnt, r_e.cyc);
        end
      end else begin
        chk("rdata_hold", rdata, last_rd);
      end
    end
    last_rd = rdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic w, input int a, input logic [W-1:0] d);
    we[k] = w;
    addr[k*A +: A] = A'(a);
    wdata[k*W +: W] = d;
  endtask

  task automatic push_g(input int k, input logic w, input int a, input logic [W-1:0] d, input int c);
    gexp_t e;
    e.gnt = N'(1 << k);
    e.addr = A'(a);
    e.load = w;
    e.din = d;
    e.cyc = c;
    gq.push_back(e);
  endtask

  task automatic push_r(input logic [W-1:0] d, input int k, input int c);
    rexp_t e;
    e.data = d;
    e.id = N'(1 << k);
    e.cyc = c;
    rq.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_rid"}, rid, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_bank_load"}, bank_load, 0);
    chk({tag, "_bank_addr"}, bank_addr, 0);
    chk({tag, "_bank_in"}, bank_in, 0);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    chk_reset_outputs("rst");
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && req != '0; i++) begin
      step();
      req = req & ~gnt;
    end
    chk({tag, "_drained"}, req, 0);
  endtask

  int c;

  initial begin
    rst_n = 1'b0;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
`ifdef REG_ARB_LOCK_EN
    lock = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("init");
    rst_n = 1'b1;

    // Reset while a write of BEEF is on the bank lines.
    step();
    set_lane(0, 1'b1, 7, 16'hBEEF);
    req = 4'b0001;
    step();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_load", bank_load, 1'b1);
    req = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("t1");
    step();
    chk("t1_bank7", bank_mem[7], 16'hF007);
    rst_n = 1'b1;

    // Single write then read of addr 3.
    step();
    c = cyc_cnt;
    set_lane(0, 1'b1, 3, 16'h1234);
    req = 4'b0001;
    push_g(0, 1'b1, 3, 16'h1234, c + 1);
    step();
    req = '0;
    step();
    c = cyc_cnt;
    set_lane(0, 1'b0, 3, 16'h0000);
    req = 4'b0001;
    push_g(0, 1'b0, 3, 16'h0000, c + 1);
    push_r(16'h1234, 0, c + 2);
    step();
    req = '0;
    step();
    step();

    do_reset();

    // Round robin from reset: writes 0..3, then reads back 0..3.
    step();
    c = cyc_cnt;
    for (int k = 0; k < N; k++) begin
      set_lane(k, 1'b1, k, 16'h3000 + 16'(k));
      push_g(k, 1'b1, k, 16'h3000 + 16'(k), c + 1 + k);
    end
    req = 4'b1111;
    drain("t3a");
    step();
    c = cyc_cnt;
    for (int k = 0; k < N; k++) begin
      set_lane(k, 1'b0, k, 16'h0000);
      push_g(k, 1'b0, k, 16'h0000, c + 1 + k);
      push_r(16'h3000 + 16'(k), k, c + 2 + k);
    end
    req = 4'b1111;
    drain("t3b");

    // Requesters 1 and 3 held for 20 cycles alternate.
    step();
    c = cyc_cnt;
    set_lane(1, 1'b1, 6, 16'h6161);
    set_lane(3, 1'b1, 0, 16'h7373);
    req = 4'b1010;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) push_g(1, 1'b1, 6, 16'h6161, c + 1 + i);
      else            push_g(3, 1'b1, 0, 16'h7373, c + 1 + i);
    end
    repeat (20) step();
    req = '0;
    step();

    // Write then read of addr 5 on consecutive grants.
    c = cyc_cnt;
    set_lane(0, 1'b1, 5, 16'hAAAA);
    set_lane(1, 1'b0, 5, 16'h0000);
    req = 4'b0011;
    push_g(0, 1'b1, 5, 16'hAAAA, c + 1);
    push_g(1, 1'b0, 5, 16'h0000, c + 2);
    push_r(16'hAAAA, 1, c + 3);
    drain("t5");

`ifdef REG_ARB_LOCK_EN
    // Locked read-modify-write on addr 1 holds off requester 0.
    step();
    c = cyc_cnt;
    set_lane(2, 1'b0, 1, 16'h0000);
    set_lane(0, 1'b1, 2, 16'h0C0C);
    lock = 4'b0100;
    req = 4'b0101;
    push_g(2, 1'b0, 1, 16'h0000, c + 1);
    push_r(16'h3001, 2, c + 2);
    push_g(2, 1'b1, 1, 16'h5A5A, c + 2);
    push_g(0, 1'b1, 2, 16'h0C0C, c + 3);
    step();
    set_lane(2, 1'b1, 1, 16'h5A5A);
    step();
    req[2] = 1'b0;
    lock = '0;
    step();
    req[0] = 1'b0;
    step();
    chk("t6_bank1", bank_mem[1], 16'h5A5A);
`endif

    repeat (5) step();
    chk("gq_empty", gq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("bank5", bank_mem[5], 16'hAAAA);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
